// File: rtl/instr_mem_loadable.sv
// ============================================================================
// instr_mem_loadable: byte-addressed instruction store, zero-filled after reset,
// byte-loadable, serving registered little-endian multi-byte fetches. Rev 1.0
// ============================================================================
`default_nettype none

module instr_mem_loadable #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 2,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic [8*INSTR_BYTES-1:0] fetch_data,
  output logic                     fetch_valid,
  output logic                     fetch_misalign,
  input  logic                     load_en,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int                DEPTH        = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_cnt;
  logic [7:0]               r_mem [DEPTH];
  logic [8*INSTR_BYTES-1:0] w_word;
  logic                     w_misalign;

  // Byte addresses wrap naturally through ADDR_W-bit addition.
  for (genvar i = 0; i < INSTR_BYTES; i++) begin : g_bytes
    assign w_word[8*i +: 8] = r_mem[fetch_addr + ADDR_W'(i)];
  end

  if (ALIGN_CHECK) begin : g_align
    assign w_misalign = |(fetch_addr & c_ALIGN_MASK);
  end else begin : g_noalign
    assign w_misalign = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_CLEAR;
      r_cnt          <= '0;
      busy           <= 1'b1;
      fetch_data     <= '0;
      fetch_valid    <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == c_LAST_ADDR) begin
            r_state <= S_RUN;
            busy    <= 1'b0;
          end
        end
        S_RUN: begin
          if (load_en) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
          end
          if (fetch_req) begin
            fetch_valid    <= 1'b1;
            fetch_data     <= w_word;
            fetch_misalign <= w_misalign;
          end
        end
        S_LOAD: begin
          if (!load_en) begin
            r_state <= S_RUN;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= 8'h00;
    end else if (r_state == S_LOAD && wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

endmodule

`default_nettype wire
